// File: rtl/mem_arbiter2_if.sv
// Bundle of signals between the two requesters, the arbiter and the single-port block memory.
// The arbiter uses the slave view; the processor side and memory use the master view.
interface mem_arbiter2_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
);
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              ack0;
    logic [DATA_W-1:0] rdata0;

    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              ack1;
    logic [DATA_W-1:0] rdata1;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;
    logic              busy;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_dout,
        output ack0, rdata0, ack1, rdata1,
        output mem_we, mem_addr, mem_din, busy
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_dout,
        input  ack0, rdata0, ack1, rdata1,
        input  mem_we, mem_addr, mem_din, busy
    );
endinterface

// File: rtl/mem_arbiter2.sv
// Two-port arbiter in front of a single-port block memory: one access at a time,
// IDLE -> ACCESS -> WAIT (READ_LAT cycles) -> RESP, with a one-cycle ack to the winner.
module mem_arbiter2 #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 16,
    parameter int READ_LAT   = 1,
    parameter int FIXED_PRIO = 0
) (
    input logic           clka,
    input logic           rst,
    mem_arbiter2_if.slave bus
);
    localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              winner, winner_d;
    logic              last_grant, last_grant_d;
    logic              is_write, is_write_d;
    logic              mem_we, mem_we_d;
    logic [ADDR_W-1:0] mem_addr, mem_addr_d;
    logic [DATA_W-1:0] mem_din, mem_din_d;
    logic              ack0, ack0_d, ack1, ack1_d;
    logic [DATA_W-1:0] rdata0, rdata0_d, rdata1, rdata1_d;
    logic              busy, busy_d;
    logic              pick;

    // Ties go to port 1 in fixed mode, otherwise to the port that did not win last time
    always_comb begin
        if (bus.req0 && bus.req1)
            pick = (FIXED_PRIO != 0) ? 1'b1 : ~last_grant;
        else
            pick = bus.req1;
    end

    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        winner_d     = winner;
        last_grant_d = last_grant;
        is_write_d   = is_write;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr;
        mem_din_d    = mem_din;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        rdata0_d     = rdata0;
        rdata1_d     = rdata1;
        case (state)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    winner_d     = pick;
                    last_grant_d = pick;
                    mem_addr_d   = pick ? bus.addr1  : bus.addr0;
                    mem_din_d    = pick ? bus.wdata1 : bus.wdata0;
                    mem_we_d     = pick ? bus.we1    : bus.we0;
                    is_write_d   = pick ? bus.we1    : bus.we0;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt == CNT_W'(READ_LAT - 1)) begin
                    if (!is_write) begin
                        if (winner) rdata1_d = bus.mem_dout;
                        else        rdata0_d = bus.mem_dout;
                    end
                    ack0_d  = ~winner;
                    ack1_d  = winner;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            winner     <= 1'b0;
            last_grant <= 1'b1;
            is_write   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_din    <= '0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            winner     <= winner_d;
            last_grant <= last_grant_d;
            is_write   <= is_write_d;
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            mem_din    <= mem_din_d;
            ack0       <= ack0_d;
            ack1       <= ack1_d;
            rdata0     <= rdata0_d;
            rdata1     <= rdata1_d;
            busy       <= busy_d;
        end
    end

    assign bus.mem_we   = mem_we;
    assign bus.mem_addr = mem_addr;
    assign bus.mem_din  = mem_din;
    assign bus.ack0     = ack0;
    assign bus.ack1     = ack1;
    assign bus.rdata0   = rdata0;
    assign bus.rdata1   = rdata1;
    assign bus.busy     = busy;
endmodule

// File: tb/tb_mem_arbiter2.sv
// Directed bench for mem_arbiter2: round-robin, fixed-priority and two-cycle-latency instances,
// each in front of a behavioural block memory whose word at address i starts as 16'h1000 + i.
module tb_mem_arbiter2;
    logic clka;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    mem_arbiter2_if #(.ADDR_W(10), .DATA_W(16)) if_rr ();
    mem_arbiter2_if #(.ADDR_W(10), .DATA_W(16)) if_fp ();
    mem_arbiter2_if #(.ADDR_W(10), .DATA_W(16)) if_l2 ();

    mem_arbiter2 #(.ADDR_W(10), .DATA_W(16), .READ_LAT(1), .FIXED_PRIO(0)) u_rr (
        .clka(clka), .rst(rst), .bus(if_rr));
    mem_arbiter2 #(.ADDR_W(10), .DATA_W(16), .READ_LAT(1), .FIXED_PRIO(1)) u_fp (
        .clka(clka), .rst(rst), .bus(if_fp));
    mem_arbiter2 #(.ADDR_W(10), .DATA_W(16), .READ_LAT(2), .FIXED_PRIO(0)) u_l2 (
        .clka(clka), .rst(rst), .bus(if_l2));

    logic [15:0] mem_rr [0:1023];
    logic [15:0] mem_fp [0:1023];
    logic [15:0] mem_l2 [0:1023];
    logic [15:0] rr_q, fp_q, l2_q1, l2_q2;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem_rr[i] <= 16'(16'h1000 + i);
            mem_fp[i] <= 16'(16'h1000 + i);
            mem_l2[i] <= 16'(16'h1000 + i);
        end
    end

    // Behavioural block memories: write on the edge, registered read of READ_LAT stages
    always @(posedge clka) begin
        if (if_rr.mem_we) mem_rr[if_rr.mem_addr] <= if_rr.mem_din;
        rr_q <= mem_rr[if_rr.mem_addr];
        if (if_fp.mem_we) mem_fp[if_fp.mem_addr] <= if_fp.mem_din;
        fp_q <= mem_fp[if_fp.mem_addr];
        if (if_l2.mem_we) mem_l2[if_l2.mem_addr] <= if_l2.mem_din;
        l2_q1 <= mem_l2[if_l2.mem_addr];
        l2_q2 <= l2_q1;
    end

    assign if_rr.mem_dout = rr_q;
    assign if_fp.mem_dout = fp_q;
    assign if_l2.mem_dout = l2_q2;

    initial clka = 1'b0;
    always #5 clka = ~clka;

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Raise a request on the round-robin instance with the given fields
    task automatic applyStimulus(input bit port, input bit we, input logic [9:0] addr, input logic [15:0] wdata);
        if (port) begin
            if_rr.req1 = 1'b1; if_rr.we1 = we; if_rr.addr1 = addr; if_rr.wdata1 = wdata;
        end else begin
            if_rr.req0 = 1'b1; if_rr.we0 = we; if_rr.addr0 = addr; if_rr.wdata0 = wdata;
        end
    endtask

    task automatic clearRequests();
        if_rr.req0 = 1'b0; if_rr.we0 = 1'b0; if_rr.addr0 = '0; if_rr.wdata0 = '0;
        if_rr.req1 = 1'b0; if_rr.we1 = 1'b0; if_rr.addr1 = '0; if_rr.wdata1 = '0;
        if_fp.req0 = 1'b0; if_fp.we0 = 1'b0; if_fp.addr0 = '0; if_fp.wdata0 = '0;
        if_fp.req1 = 1'b0; if_fp.we1 = 1'b0; if_fp.addr1 = '0; if_fp.wdata1 = '0;
        if_l2.req0 = 1'b0; if_l2.we0 = 1'b0; if_l2.addr0 = '0; if_l2.wdata0 = '0;
        if_l2.req1 = 1'b0; if_l2.we1 = 1'b0; if_l2.addr1 = '0; if_l2.wdata1 = '0;
    endtask

    initial begin
        rst = 1'b1;
        clearRequests();
        tick();
        tick();

        // Reset state
        checkOutput("rst_mem_we",   if_rr.mem_we,   0);
        checkOutput("rst_mem_addr", if_rr.mem_addr, 0);
        checkOutput("rst_mem_din",  if_rr.mem_din,  0);
        checkOutput("rst_acks",     {if_rr.ack0, if_rr.ack1}, 0);
        checkOutput("rst_rdata",    {if_rr.rdata0, if_rr.rdata1}, 0);
        checkOutput("rst_busy",     if_rr.busy,     0);
        rst = 1'b0;
        tick();
        checkOutput("idle_no_we", if_rr.mem_we, 0);

        // Port 1 write then read back
        applyStimulus(1'b1, 1'b1, 10'd4, 16'd6);
        tick();
        checkOutput("wr_mem_we",   if_rr.mem_we,   1);
        checkOutput("wr_mem_addr", if_rr.mem_addr, 4);
        checkOutput("wr_mem_din",  if_rr.mem_din,  6);
        checkOutput("wr_busy",     if_rr.busy,     1);
        tick();
        checkOutput("wr_we_pulse", if_rr.mem_we, 0);
        checkOutput("wr_ack_early", if_rr.ack1, 0);
        tick();
        checkOutput("wr_ack1", if_rr.ack1, 1);
        checkOutput("wr_ack0", if_rr.ack0, 0);
        clearRequests();
        tick();
        checkOutput("wr_ack_pulse", if_rr.ack1, 0);
        checkOutput("wr_idle_busy", if_rr.busy, 0);
        checkOutput("wr_mem_word",  mem_rr[4], 16'd6);

        applyStimulus(1'b1, 1'b0, 10'd4, 16'd0);
        tick();
        checkOutput("rd_mem_we", if_rr.mem_we, 0);
        tick();
        tick();
        checkOutput("rd_ack1",   if_rr.ack1,   1);
        checkOutput("rd_rdata1", if_rr.rdata1, 6);
        checkOutput("rd_rdata0", if_rr.rdata0, 0);
        clearRequests();
        tick();

        // Tie with both requests held from reset: grants alternate 0,1,0,1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if_rr.req0 = 1'b1; if_rr.addr0 = 10'd10;
        if_rr.req1 = 1'b1; if_rr.addr1 = 10'd11;
        for (int g = 0; g < 4; g++) begin
            tick();
            checkOutput($sformatf("rr_addr%0d", g), if_rr.mem_addr, (g % 2) ? 11 : 10);
            tick();
            tick();
            checkOutput($sformatf("rr_acks%0d", g), {if_rr.ack1, if_rr.ack0}, (g % 2) ? 2'b10 : 2'b01);
            if (g % 2)
                checkOutput($sformatf("rr_rdata1_%0d", g), if_rr.rdata1, 16'h100B);
            else
                checkOutput($sformatf("rr_rdata0_%0d", g), if_rr.rdata0, 16'h100A);
            if (g == 3) clearRequests();
            tick();
            checkOutput($sformatf("rr_gap%0d", g), {if_rr.ack1, if_rr.ack0}, 0);
        end
        tick();

        // Fixed priority: port 1 wins the tie even though port 0 is due a turn
        if_fp.req0 = 1'b1; if_fp.addr0 = 10'd3;
        if_fp.req1 = 1'b1; if_fp.addr1 = 10'd3;
        tick();
        tick();
        tick();
        checkOutput("fp_first", {if_fp.ack1, if_fp.ack0}, 2'b10);
        checkOutput("fp_rdata1", if_fp.rdata1, 16'h1003);
        if_fp.req1 = 1'b0;
        tick();
        tick();
        tick();
        tick();
        checkOutput("fp_second", {if_fp.ack1, if_fp.ack0}, 2'b01);
        checkOutput("fp_rdata0", if_fp.rdata0, 16'h1003);
        clearRequests();
        tick();

        // Reset mid-cycle during the ACCESS of a write to address 0
        applyStimulus(1'b0, 1'b1, 10'd0, 16'd2);
        tick();
        checkOutput("ab_we_before", if_rr.mem_we, 1);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("ab_we_async",   if_rr.mem_we,   0);
        checkOutput("ab_addr_async", if_rr.mem_addr, 0);
        checkOutput("ab_busy_async", if_rr.busy,     0);
        checkOutput("ab_ack_async",  if_rr.ack0,     0);
        clearRequests();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checkOutput($sformatf("ab_quiet%0d", c), {if_rr.mem_we, if_rr.ack0, if_rr.ack1}, 0);
        end
        applyStimulus(1'b0, 1'b0, 10'd0, 16'd0);
        tick();
        tick();
        tick();
        checkOutput("ab_rd_ack0",   if_rr.ack0,   1);
        checkOutput("ab_rd_rdata0", if_rr.rdata0, 16'h1000);
        clearRequests();
        tick();

        // Two-cycle read latency: ack one cycle later than the single-cycle instance
        if_l2.req1 = 1'b1; if_l2.addr1 = 10'd1;
        tick();
        tick();
        checkOutput("l2_wait1", if_l2.ack1, 0);
        tick();
        checkOutput("l2_wait2", if_l2.ack1, 0);
        checkOutput("l2_busy",  if_l2.busy, 1);
        tick();
        checkOutput("l2_ack1",   if_l2.ack1,   1);
        checkOutput("l2_rdata1", if_l2.rdata1, 16'h1001);
        clearRequests();
        tick();
        checkOutput("l2_ack_pulse", if_l2.ack1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
